// File: rtl/wallace_acc_pkg.sv
// Shared types and helpers for the Wallace product accumulator.
package wallace_acc_pkg;

  // Product width delivered by the 8x8 Wallace multiplier.
  localparam int PROD_W = 16;

  // Frame state: IDLE waits for a first term, ACCUM sums terms,
  // HOLD presents the finished frame until downstream takes it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Mask that zeroes the lowest 'lsbs' bits of a product.
  function automatic logic [PROD_W-1:0] trunc_mask(input int lsbs);
    logic [PROD_W-1:0] m;
    m = '1;
    for (int i = 0; i < PROD_W; i++) begin
      if (i < lsbs) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_acc_adder.sv
// Accumulator adder: ACC_W add with carry-out, optional clamp to all-ones.
module approx_acc_adder #(
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum_out,
  output logic             ovf
);

  logic [ACC_W:0] full_sum;

  // Add with one extra bit to catch the carry, then wrap or clamp.
  always_comb begin
    full_sum = {1'b0, acc_in} + {1'b0, addend};
    ovf      = full_sum[ACC_W];
    if (SATURATE && full_sum[ACC_W]) sum_out = '1;
    else                             sum_out = full_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/wallace_product_accumulator.sv
// Accumulates FRAME_LEN multiplier products into one frame sum.
// Stage 1 captures (and optionally truncates) the accepted product,
// stage 2 adds it into the accumulator.
//
// Handshakes: a transfer happens on a rising edge where valid && ready
// are both high. prod_ready is combinational (never depends on
// prod_valid); acc_valid is registered and acc_out/overflow/term_count
// stay stable while acc_valid is high and acc_ready is low.
module wallace_product_accumulator
  import wallace_acc_pkg::*;
#(
  parameter int PROD_W      = 16,
  parameter int ACC_W       = 24,
  parameter int FRAME_LEN   = 16,
  parameter int APPROX_LSBS = 0,
  parameter bit SATURATE    = 1'b1,
  localparam int CNT_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  term_count
);

  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [PROD_W-1:0] P_MASK    = trunc_mask(APPROX_LSBS);

  acc_state_e        state_q, state_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              p_vld_q, p_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              live_q;   // low during reset and the edge leaving it
  logic              accept;
  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;

  assign prod_ready = live_q && !clear && (state_q != HOLD) && (cnt_q < FRAME_CNT);
  assign accept     = prod_valid && prod_ready;

  approx_acc_adder #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .acc_in  (acc_q),
    .addend  (ACC_W'(p_q)),
    .sum_out (add_sum),
    .ovf     (add_ovf)
  );

  // Next-state for the capture stage, the accumulator and the frame FSM.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        p_d     = prod_in & P_MASK;
        p_vld_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      if (p_vld_q) begin
        acc_d = add_sum;
        if (add_ovf) ovf_d = 1'b1;
      end
      case (state_q)
        IDLE:    if (accept) state_d = ACCUM;
        ACCUM:   if (p_vld_q && (cnt_q == FRAME_CNT)) state_d = HOLD;
        HOLD: begin
          if (acc_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  assign acc_out    = acc_q;
  assign acc_valid  = (state_q == HOLD);
  assign overflow   = ovf_q;
  assign term_count = cnt_q;

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Directed bench for wallace_product_accumulator: four parameterisations
// (exact, truncated, saturating 18-bit, wrapping 18-bit) share a reset.
module tb_wallace_product_accumulator;

  localparam int ND = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] prod_in    [ND];
  logic        prod_valid [ND];
  logic        clear      [ND];
  logic        acc_ready  [ND];
  logic        prod_ready [ND];
  logic        acc_valid  [ND];
  logic        overflow   [ND];
  logic [2:0]  term_count [ND];
  logic [23:0] acc_a0, acc_a1;
  logic [17:0] acc_b2, acc_b3;
  logic [23:0] acc_view   [ND];

  always_comb begin
    acc_view[0] = acc_a0;
    acc_view[1] = acc_a1;
    acc_view[2] = {6'd0, acc_b2};
    acc_view[3] = {6'd0, acc_b3};
  end

  wallace_product_accumulator #(.ACC_W(24), .FRAME_LEN(4), .APPROX_LSBS(0), .SATURATE(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in[0]), .prod_valid(prod_valid[0]),
    .prod_ready(prod_ready[0]), .clear(clear[0]), .acc_out(acc_a0), .acc_valid(acc_valid[0]),
    .acc_ready(acc_ready[0]), .overflow(overflow[0]), .term_count(term_count[0]));

  wallace_product_accumulator #(.ACC_W(24), .FRAME_LEN(4), .APPROX_LSBS(4), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in[1]), .prod_valid(prod_valid[1]),
    .prod_ready(prod_ready[1]), .clear(clear[1]), .acc_out(acc_a1), .acc_valid(acc_valid[1]),
    .acc_ready(acc_ready[1]), .overflow(overflow[1]), .term_count(term_count[1]));

  wallace_product_accumulator #(.ACC_W(18), .FRAME_LEN(5), .APPROX_LSBS(0), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in[2]), .prod_valid(prod_valid[2]),
    .prod_ready(prod_ready[2]), .clear(clear[2]), .acc_out(acc_b2), .acc_valid(acc_valid[2]),
    .acc_ready(acc_ready[2]), .overflow(overflow[2]), .term_count(term_count[2]));

  wallace_product_accumulator #(.ACC_W(18), .FRAME_LEN(5), .APPROX_LSBS(0), .SATURATE(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in[3]), .prod_valid(prod_valid[3]),
    .prod_ready(prod_ready[3]), .clear(clear[3]), .acc_out(acc_b3), .acc_valid(acc_valid[3]),
    .acc_ready(acc_ready[3]), .overflow(overflow[3]), .term_count(term_count[3]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;
    int          n;
    logic [15:0] p [5];
    logic [23:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  function automatic vec_t mk(input int d, input int n, input int a, input int b,
                              input int c, input int e, input int f,
                              input int acc, input bit ovf);
    vec_t v;
    v.dut = d; v.n = n;
    v.p[0] = 16'(a); v.p[1] = 16'(b); v.p[2] = 16'(c); v.p[3] = 16'(e); v.p[4] = 16'(f);
    v.exp_acc = 24'(acc); v.exp_ovf = ovf;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Feeds v.n back-to-back terms, then checks the result two cycles after
  // the last accept. Leaves the DUT in HOLD, sampling point negedge+1.
  task automatic run_frame(input vec_t v, input string tag);
    int d;
    d = v.dut;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      prod_in[d] = v.p[k];
      prod_valid[d] = 1'b1;
      #1;
      check($sformatf("%s ready_t%0d", tag, k), 32'(prod_ready[d]), 32'd1);
    end
    @(negedge clk);
    prod_valid[d] = 1'b0;
    #1;
    check({tag, " ready_drop"}, 32'(prod_ready[d]), 32'd0);
    check({tag, " valid_early"}, 32'(acc_valid[d]), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " acc_valid"}, 32'(acc_valid[d]), 32'd1);
    check({tag, " acc_out"}, 32'(acc_view[d]), 32'(v.exp_acc));
    check({tag, " overflow"}, 32'(overflow[d]), 32'(v.exp_ovf));
    check({tag, " term_count"}, 32'(term_count[d]), 32'(v.n));
  endtask

  task automatic handshake(input int d, input string tag);
    acc_ready[d] = 1'b1;
    @(negedge clk);
    acc_ready[d] = 1'b0;
    #1;
    check({tag, " hs_valid"}, 32'(acc_valid[d]), 32'd0);
    check({tag, " hs_acc"}, 32'(acc_view[d]), 32'd0);
    check({tag, " hs_ovf"}, 32'(overflow[d]), 32'd0);
    check({tag, " hs_cnt"}, 32'(term_count[d]), 32'd0);
    check({tag, " hs_ready"}, 32'(prod_ready[d]), 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = mk(0, 4, 65025, 1, 2, 3, 0, 65031, 1'b0);
    vecs[1] = mk(1, 4, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 0, 960, 1'b0);
    vecs[2] = mk(2, 5, 65025, 65025, 65025, 65025, 65025, 262143, 1'b1);
    vecs[3] = mk(3, 5, 65025, 65025, 65025, 65025, 65025, 62981, 1'b1);
    vecs[4] = mk(0, 4, 100, 200, 300, 400, 0, 1000, 1'b0);
    vecs[5] = mk(0, 4, 65535, 65535, 65535, 65535, 0, 262140, 1'b0);
    vecs[6] = mk(1, 4, 16'h1234, 16'h000F, 16'hFFFF, 16'h0010, 0, 70192, 1'b0);
    vecs[7] = mk(2, 5, 1, 2, 3, 4, 5, 15, 1'b0);

    for (int i = 0; i < ND; i++) begin
      prod_in[i] = '0; prod_valid[i] = 1'b0; clear[i] = 1'b0; acc_ready[i] = 1'b0;
    end

    // Reset state
    #12;
    check("rst ready", 32'(prod_ready[0]), 32'd0);
    check("rst valid", 32'(acc_valid[0]), 32'd0);
    check("rst acc", 32'(acc_view[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst ready", 32'(prod_ready[0]), 32'd1);
    check("post_rst cnt", 32'(term_count[0]), 32'd0);

    // Reset mid-frame
    @(negedge clk); prod_in[0] = 16'd1; prod_valid[0] = 1'b1;
    @(negedge clk); prod_in[0] = 16'd2;
    @(negedge clk); prod_in[0] = 16'd3;
    @(negedge clk); prod_valid[0] = 1'b0;
    #1;
    check("mid acc_pre", 32'(acc_view[0]), 32'd3);
    check("mid cnt_pre", 32'(term_count[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst acc", 32'(acc_view[0]), 32'd0);
    check("mid rst cnt", 32'(term_count[0]), 32'd0);
    check("mid rst ready", 32'(prod_ready[0]), 32'd0);
    check("mid rst ovf", 32'(overflow[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid rel ready0", 32'(prod_ready[0]), 32'd0);
    @(negedge clk);
    #1;
    check("mid rel ready1", 32'(prod_ready[0]), 32'd1);
    check("mid rel cnt", 32'(term_count[0]), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      handshake(vecs[i].dut, $sformatf("vec%0d", i));
    end

    // Backpressure in HOLD with prod_valid asserted
    run_frame(mk(0, 4, 11, 22, 33, 44, 0, 110, 1'b0), "bp");
    for (int c = 0; c < 5; c++) begin
      prod_in[0] = 16'd7; prod_valid[0] = 1'b1; acc_ready[0] = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("bp valid_c%0d", c), 32'(acc_valid[0]), 32'd1);
      check($sformatf("bp acc_c%0d", c), 32'(acc_view[0]), 32'd110);
      check($sformatf("bp cnt_c%0d", c), 32'(term_count[0]), 32'd4);
      check($sformatf("bp ready_c%0d", c), 32'(prod_ready[0]), 32'd0);
    end
    acc_ready[0] = 1'b1;
    #1;
    check("bp hs_cycle ready", 32'(prod_ready[0]), 32'd0);
    @(negedge clk);
    acc_ready[0] = 1'b0;
    #1;
    check("bp after_hs valid", 32'(acc_valid[0]), 32'd0);
    check("bp after_hs cnt", 32'(term_count[0]), 32'd0);
    check("bp after_hs ready", 32'(prod_ready[0]), 32'd1);
    @(negedge clk);
    #1;
    check("bp new_frame cnt", 32'(term_count[0]), 32'd1);
    prod_in[0] = 16'd8;
    @(negedge clk); prod_in[0] = 16'd9;
    @(negedge clk); prod_in[0] = 16'd10;
    @(negedge clk); prod_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    check("bp f2 valid", 32'(acc_valid[0]), 32'd1);
    check("bp f2 acc", 32'(acc_view[0]), 32'd34);
    handshake(0, "bp f2");

    // Clear mid-frame with a term presented in the clear cycle
    @(negedge clk); prod_in[0] = 16'd5; prod_valid[0] = 1'b1;
    @(negedge clk); prod_in[0] = 16'd6;
    @(negedge clk); prod_in[0] = 16'd1000; clear[0] = 1'b1;
    #1;
    check("clr ready", 32'(prod_ready[0]), 32'd0);
    @(negedge clk);
    clear[0] = 1'b0; prod_valid[0] = 1'b0;
    #1;
    check("clr acc", 32'(acc_view[0]), 32'd0);
    check("clr cnt", 32'(term_count[0]), 32'd0);
    check("clr valid", 32'(acc_valid[0]), 32'd0);
    check("clr state", 32'(u0.state_q), 32'd0);
    @(negedge clk);
    #1;
    check("clr idle acc", 32'(acc_view[0]), 32'd0);
    run_frame(mk(0, 4, 10, 20, 30, 40, 0, 100, 1'b0), "clr f");
    handshake(0, "clr f");

    // Clear while holding a result drops it
    run_frame(mk(0, 4, 1, 1, 1, 1, 0, 4, 1'b0), "clrh");
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    #1;
    check("clrh valid", 32'(acc_valid[0]), 32'd0);
    check("clrh acc", 32'(acc_view[0]), 32'd0);
    check("clrh ready", 32'(prod_ready[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
